// File: rtl/frog_pkg.sv
// Shared definitions for the frog game input path: direction codes and the
// fixed-priority pick used when draining queued moves.
package frog_pkg;

  localparam int NUM_BTNS = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef struct packed {
    logic found;
    dir_e dir;
  } pick_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Lowest set bit wins, so UP beats DOWN beats LEFT beats RIGHT.
  function automatic pick_t pick_highest(input logic [NUM_BTNS-1:0] req);
    pick_t p;
    p.found = 1'b0;
    p.dir   = DIR_UP;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (req[i]) begin
        p.found = 1'b1;
        p.dir   = dir_e'(i[1:0]);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton: 2-flop synchroniser, stability-count debounce, press event
// and optional hold-to-repeat timer.
module button_debounce
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic evt
);

  localparam int DB_W = max_int($clog2(DEBOUNCE_CYCLES), 1);
  localparam int HC_W = max_int($clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES)), 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;
  logic            flip;
  logic            press_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
    end
  end

  assign flip      = (sync2 != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign press_now = flip && sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync2 == level) begin
      db_cnt <= '0;
    end else if (flip) begin
      level  <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      logic [HC_W-1:0] hold_cnt;
      logic            first;
      logic            rpt_tc;

      // First repeat waits the long hold delay, later ones the short period.
      assign rpt_tc = first ? (hold_cnt == HC_W'(HOLD_CYCLES - 1))
                            : (hold_cnt == HC_W'(REPEAT_CYCLES - 1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_cnt <= '0;
          first    <= 1'b0;
          evt      <= 1'b0;
        end else begin
          evt <= 1'b0;
          if (press_now) begin
            evt      <= 1'b1;
            hold_cnt <= '0;
            first    <= 1'b1;
          end else if (!level || flip) begin
            // Released, or being released this cycle: no repeat may slip out.
            hold_cnt <= '0;
            first    <= 1'b0;
          end else if (rpt_tc) begin
            evt      <= 1'b1;
            hold_cnt <= '0;
            first    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end
    end else begin : g_norpt
      always_ff @(posedge clk or posedge reset) begin
        if (reset) evt <= 1'b0;
        else       evt <= press_now;
      end
    end
  endgenerate

endmodule

// File: rtl/frog_input_conditioner.sv
// Pushbuttons to move commands: per-button conditioning, sticky per-direction
// pending bits, fixed-priority pick and a valid/ready output register.
module frog_input_conditioner
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] held
);

  logic [NUM_BTNS-1:0] btn_n;
  logic [NUM_BTNS-1:0] lvl;
  logic [NUM_BTNS-1:0] evt;
  logic [NUM_BTNS-1:0] pending;
  logic [NUM_BTNS-1:0] pending_clr;
  pick_t               pick;
  logic                load;

  // Bit index equals the direction code.
  assign btn_n = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

  generate
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_btn (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_n[i]),
        .level(lvl[i]),
        .evt  (evt[i])
      );
    end
  endgenerate

  assign held = lvl;
  assign load = !move_valid || move_ready;
  assign pick = pick_highest(pending);

  always_comb begin
    pending_clr = '0;
    if (load && pick.found) pending_clr[pick.dir] = 1'b1;
  end

  // Set wins over clear so an event landing on the load cycle is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~pending_clr) | evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
    end else if (load) begin
      move_valid <= pick.found;
      if (pick.found) move_dir <= pick.dir;
    end
  end

endmodule
